// File: rtl/gpio_pkg.sv
// gpio_pkg: shared definitions for the GPIO pad controller.
//   - config-word bit indices and read-only/W1C status bit indices
//   - gpio_cfg_t: packed per-pin configuration (bit 0 = out ... bit 8 = fall_en)
//   - GPIO_CFG_RST: per-pin reset configuration (input enabled, no drive, no pull)
//   - cfg_from_word: converts a written config word into gpio_cfg_t
package gpio_pkg;

    localparam int unsigned CFG_OUT     = 0;
    localparam int unsigned CFG_OE      = 1;
    localparam int unsigned CFG_IE      = 2;
    localparam int unsigned CFG_CS      = 3;
    localparam int unsigned CFG_SL      = 4;
    localparam int unsigned CFG_PU      = 5;
    localparam int unsigned CFG_PD      = 6;
    localparam int unsigned CFG_RISE_EN = 7;
    localparam int unsigned CFG_FALL_EN = 8;
    localparam int unsigned CFG_W       = 9;

    localparam int unsigned RD_SYNC     = 16;
    localparam int unsigned RD_RISE     = 17;
    localparam int unsigned RD_FALL     = 18;

    // Field order puts out at bit 0 so the struct maps directly onto word[8:0].
    typedef struct packed {
        logic fall_en;
        logic rise_en;
        logic pd;
        logic pu;
        logic sl;
        logic cs;
        logic ie;
        logic oe;
        logic out;
    } gpio_cfg_t;

    localparam gpio_cfg_t GPIO_CFG_RST = '{
        fall_en: 1'b0, rise_en: 1'b0, pd: 1'b0, pu: 1'b0,
        sl: 1'b0, cs: 1'b0, ie: 1'b1, oe: 1'b0, out: 1'b0
    };

    // Pull-up wins when both pulls are requested, so the pad never fights itself.
    function automatic gpio_cfg_t cfg_from_word(input logic [CFG_W-1:0] w);
        gpio_cfg_t c;
        c.out     = w[CFG_OUT];
        c.oe      = w[CFG_OE];
        c.ie      = w[CFG_IE];
        c.cs      = w[CFG_CS];
        c.sl      = w[CFG_SL];
        c.pu      = w[CFG_PU];
        c.pd      = w[CFG_PD] & ~w[CFG_PU];
        c.rise_en = w[CFG_RISE_EN];
        c.fall_en = w[CFG_FALL_EN];
        return c;
    endfunction

endpackage

// File: rtl/gpio_pad_ctrl_pin.sv
// gpio_pad_ctrl_pin: one GPIO pin slice.
//   Holds the pin's config register, a 2-flop input synchroniser, an optional
//   debounce filter (GPIO_DEBOUNCE_EN), a previous-value flop and the sticky
//   rise/fall pending flags.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   cfg_we         load cfg_wdata into the config register
//   cfg_wdata      new configuration
//   rise_clr       W1C request for rise_pend
//   fall_clr       W1C request for fall_pend
//   pad_in         raw pad input (asynchronous)
//   cfg            current configuration
//   filt           synchronised (and optionally debounced) input
//   rise_pend      sticky rising-edge flag
//   fall_pend      sticky falling-edge flag
module gpio_pad_ctrl_pin
    import gpio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      cfg_we,
    input  gpio_cfg_t cfg_wdata,
    input  logic      rise_clr,
    input  logic      fall_clr,
    input  logic      pad_in,
    output gpio_cfg_t cfg,
    output logic      filt,
    output logic      rise_pend,
    output logic      fall_pend
);

    logic [1:0] sync_q;
    logic       prev_q;
    logic       rise_c;
    logic       fall_c;

`ifdef GPIO_DEBOUNCE_EN
    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             filt_q;

    // Filtered value follows the synced input only after it has disagreed for
    // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else if (sync_q[1] != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_q <= sync_q[1];
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_q <= '0;
        end
    end

    assign filt = filt_q;
`else
    logic unused_dbc;
    assign unused_dbc = ^32'(DEBOUNCE_CYCLES);
    assign filt       = sync_q[1];
`endif

    // Edge events are gated by the pin's input enable and per-direction enable.
    assign rise_c = filt & ~prev_q & cfg.ie & cfg.rise_en;
    assign fall_c = ~filt & prev_q & cfg.ie & cfg.fall_en;

    // Config, synchroniser, history and sticky flags (a new event beats W1C).
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg       <= GPIO_CFG_RST;
            sync_q    <= 2'b00;
            prev_q    <= 1'b0;
            rise_pend <= 1'b0;
            fall_pend <= 1'b0;
        end else begin
            if (cfg_we) begin
                cfg <= cfg_wdata;
            end
            sync_q    <= {sync_q[0], pad_in};
            prev_q    <= filt;
            rise_pend <= rise_c | (rise_pend & ~rise_clr);
            fall_pend <= fall_c | (fall_pend & ~fall_clr);
        end
    end

endmodule

// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: per-pin register bank driving the bidir pad control lines,
// with synchronised input capture, edge detection and a level interrupt.
// Optional input debounce is built when GPIO_DEBOUNCE_EN is defined.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reg_we, reg_re            register write / read strobes
//   reg_addr                  pin index
//   reg_wdata                 write data (config [8:0], W1C [18:17])
//   reg_rdata, reg_rvalid     read data, valid one cycle after reg_re
//   bidir_in                  pad Y inputs
//   bidir_out/oe/cs/sl/ie/pu/pd  pad control outputs
//   irq                       OR of all pending flags (registered)
module gpio_pad_ctrl
    import gpio_pkg::*;
#(
    parameter int unsigned NUM_PINS        = 37,
    parameter int unsigned ADDR_W          = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                reg_we,
    input  logic                reg_re,
    input  logic [ADDR_W-1:0]   reg_addr,
    input  logic [31:0]         reg_wdata,
    output logic [31:0]         reg_rdata,
    output logic                reg_rvalid,
    input  logic [NUM_PINS-1:0] bidir_in,
    output logic [NUM_PINS-1:0] bidir_out,
    output logic [NUM_PINS-1:0] bidir_oe,
    output logic [NUM_PINS-1:0] bidir_cs,
    output logic [NUM_PINS-1:0] bidir_sl,
    output logic [NUM_PINS-1:0] bidir_ie,
    output logic [NUM_PINS-1:0] bidir_pu,
    output logic [NUM_PINS-1:0] bidir_pd,
    output logic                irq
);

    localparam int unsigned      AW1       = ADDR_W + 1;
    localparam logic [ADDR_W:0]  PIN_LIMIT = AW1'(NUM_PINS);

    gpio_cfg_t           cfg_q [NUM_PINS];
    logic [NUM_PINS-1:0] filt_v;
    logic [NUM_PINS-1:0] rise_v;
    logic [NUM_PINS-1:0] fall_v;
    gpio_cfg_t           cfg_wdata_c;
    logic                addr_ok_c;
    logic [ADDR_W-1:0]   pin_sel_c;
    logic [31:0]         rd_word_c;
    logic                unused_wdata;

    assign unused_wdata = ^{reg_wdata[31:19], reg_wdata[15:9]};
    assign cfg_wdata_c  = cfg_from_word(reg_wdata[CFG_W-1:0]);
    assign addr_ok_c    = {1'b0, reg_addr} < PIN_LIMIT;
    assign pin_sel_c    = addr_ok_c ? reg_addr : '0;

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
        logic pin_we_c;
        assign pin_we_c = reg_we && addr_ok_c && (reg_addr == ADDR_W'(i));

        gpio_pad_ctrl_pin #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_pin (
            .clk      (clk),
            .rst      (rst),
            .cfg_we   (pin_we_c),
            .cfg_wdata(cfg_wdata_c),
            .rise_clr (pin_we_c & reg_wdata[RD_RISE]),
            .fall_clr (pin_we_c & reg_wdata[RD_FALL]),
            .pad_in   (bidir_in[i]),
            .cfg      (cfg_q[i]),
            .filt     (filt_v[i]),
            .rise_pend(rise_v[i]),
            .fall_pend(fall_v[i])
        );

        assign bidir_out[i] = cfg_q[i].out;
        assign bidir_oe[i]  = cfg_q[i].oe;
        assign bidir_cs[i]  = cfg_q[i].cs;
        assign bidir_sl[i]  = cfg_q[i].sl;
        assign bidir_ie[i]  = cfg_q[i].ie;
        assign bidir_pu[i]  = cfg_q[i].pu;
        assign bidir_pd[i]  = cfg_q[i].pd;
    end

    // Read mux; out-of-range pins read as zero.
    always_comb begin
        rd_word_c = '0;
        if (addr_ok_c) begin
            rd_word_c[CFG_W-1:0] = cfg_q[pin_sel_c];
            rd_word_c[RD_SYNC]   = filt_v[pin_sel_c];
            rd_word_c[RD_RISE]   = rise_v[pin_sel_c];
            rd_word_c[RD_FALL]   = fall_v[pin_sel_c];
        end
    end

    // Read response and interrupt; rdata holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_rdata  <= '0;
            reg_rvalid <= 1'b0;
            irq        <= 1'b0;
        end else begin
            reg_rvalid <= reg_re;
            if (reg_re) begin
                reg_rdata <= rd_word_c;
            end
            irq <= |{rise_v, fall_v};
        end
    end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// tb_gpio_pad_ctrl: randomized and directed bench for gpio_pad_ctrl with a
// behavioural reference model and a read-response scoreboard.
module tb_gpio_pad_ctrl;

    localparam int NP  = 37;
    localparam int AW  = 6;
    localparam int DEB = 16;
`ifdef GPIO_DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
`else
    localparam bit DEB_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          reg_we = 1'b0;
    logic          reg_re = 1'b0;
    logic [AW-1:0] reg_addr = '0;
    logic [31:0]   reg_wdata = '0;
    logic [31:0]   reg_rdata;
    logic          reg_rvalid;
    logic [NP-1:0] bidir_in = '0;
    logic [NP-1:0] bidir_out, bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;
    logic          irq;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    gpio_pad_ctrl #(.NUM_PINS(NP), .ADDR_W(AW), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .reg_we(reg_we), .reg_re(reg_re),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid),
        .bidir_in(bidir_in), .bidir_out(bidir_out), .bidir_oe(bidir_oe),
        .bidir_cs(bidir_cs), .bidir_sl(bidir_sl), .bidir_ie(bidir_ie),
        .bidir_pu(bidir_pu), .bidir_pd(bidir_pd), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Per pin: stored config word, input delay line (s1m = last sample,
    // s2m = sample before), filtered value fm, its previous value pm.
    logic [8:0]     cfg_m [NP];
    logic [DEB-1:0] hist_m [NP];
    logic [NP-1:0]  s1m, s2m, fm, pm, rise_m, fall_m;
    logic           irq_m;
    logic [31:0]    hold_m;
    logic [31:0]    exp_q[$];

    function automatic logic [31:0] word_m(input logic [AW-1:0] a);
        logic [31:0] w = '0;
        if (int'(a) < NP) begin
            w[8:0] = cfg_m[a];
            w[16]  = fm[a];
            w[17]  = rise_m[a];
            w[18]  = fall_m[a];
        end
        return w;
    endfunction

    always @(posedge clk) begin
        logic [NP-1:0] fm_n;
        logic          hit, rs, fs;
        if (rst) begin
            for (int p = 0; p < NP; p++) begin
                cfg_m[p]  = 9'h004;
                hist_m[p] = '0;
            end
            s1m = '0; s2m = '0; fm = '0; pm = '0;
            rise_m = '0; fall_m = '0; irq_m = 1'b0; hold_m = '0;
            exp_q.delete();
        end else begin
            if (reg_re) exp_q.push_back(word_m(reg_addr));
            irq_m = |(rise_m | fall_m);
            for (int p = 0; p < NP; p++) begin
                hit = reg_we && (int'(reg_addr) == p);
                rs  = fm[p] && !pm[p] && cfg_m[p][2] && cfg_m[p][7];
                fs  = !fm[p] && pm[p] && cfg_m[p][2] && cfg_m[p][8];
                rise_m[p] = rs || (rise_m[p] && !(hit && reg_wdata[17]));
                fall_m[p] = fs || (fall_m[p] && !(hit && reg_wdata[18]));
                if (hit) begin
                    cfg_m[p] = reg_wdata[8:0];
                    if (cfg_m[p][5] && cfg_m[p][6]) cfg_m[p][6] = 1'b0;
                end
                if (DEB_ON) begin
                    hist_m[p] = {hist_m[p][DEB-2:0], s2m[p]};
                    if (fm[p] ? (hist_m[p] == '0) : (&hist_m[p])) fm_n[p] = s2m[p];
                    else fm_n[p] = fm[p];
                end else begin
                    fm_n[p] = s1m[p];
                end
            end
            pm  = fm;
            fm  = fm_n;
            s2m = s1m;
            s1m = bidir_in;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [NP-1:0] e_out, e_oe, e_cs, e_sl, e_ie, e_pu, e_pd;
        logic [31:0]   e;
        if (mon_en) begin
            if (reg_rvalid) begin
                if (exp_q.size() == 0) begin
                    chk("rvalid_unexpected", 64'(reg_rvalid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("rdata", 64'(reg_rdata), 64'(e));
                    hold_m = e;
                end
            end else begin
                chk("rdata_hold", 64'(reg_rdata), 64'(hold_m));
            end
            chk("rvalid_missing", 64'(exp_q.size()), 64'(0));
            for (int p = 0; p < NP; p++) begin
                e_out[p] = cfg_m[p][0]; e_oe[p] = cfg_m[p][1]; e_ie[p] = cfg_m[p][2];
                e_cs[p]  = cfg_m[p][3]; e_sl[p] = cfg_m[p][4]; e_pu[p] = cfg_m[p][5];
                e_pd[p]  = cfg_m[p][6];
            end
            chk("bidir_out", 64'(bidir_out), 64'(e_out));
            chk("bidir_oe",  64'(bidir_oe),  64'(e_oe));
            chk("bidir_cs",  64'(bidir_cs),  64'(e_cs));
            chk("bidir_sl",  64'(bidir_sl),  64'(e_sl));
            chk("bidir_ie",  64'(bidir_ie),  64'(e_ie));
            chk("bidir_pu",  64'(bidir_pu),  64'(e_pu));
            chk("bidir_pd",  64'(bidir_pd),  64'(e_pd));
            chk("irq",       64'(irq),       64'(irq_m));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        reg_we = 1'b1; reg_addr = AW'(a); reg_wdata = d;
        cyc();
        reg_we = 1'b0;
    endtask

    task automatic rd(input int a);
        reg_re = 1'b1; reg_addr = AW'(a);
        cyc();
        reg_re = 1'b0;
    endtask

    localparam logic [NP-1:0] ALL1 = '1;

    initial begin
        // 1: reset state and first read
        rst = 1'b1;
        cyc();
        mon_en = 1'b1;
        idle(2);
        rst = 1'b0;
        chk("rst_oe", 64'(bidir_oe), 64'(0));
        chk("rst_ie", 64'(bidir_ie), 64'(ALL1));
        chk("rst_irq", 64'(irq), 64'(0));
        chk("rst_rvalid", 64'(reg_rvalid), 64'(0));
        rd(0);
        chk("rd0_data", 64'(reg_rdata), 64'h4);
        chk("rd0_valid", 64'(reg_rvalid), 64'(1));
        cyc();
        chk("rd0_valid_drop", 64'(reg_rvalid), 64'(0));

        // 2: drive pin 5, then pull conflict
        wr(5, 32'h0000_0003);
        chk("p5_out", 64'(bidir_out[5]), 64'(1));
        chk("p5_oe", 64'(bidir_oe[5]), 64'(1));
        wr(5, 32'h0000_0060);
        chk("p5_pu", 64'(bidir_pu[5]), 64'(1));
        chk("p5_pd", 64'(bidir_pd[5]), 64'(0));

        // 3: rising edge on pin 9
        wr(9, 32'h0000_0084);
        bidir_in[9] = 1'b1;
        cyc();
        idle(2);
        chk("p9_irq_early", 64'(irq), 64'(0));
        cyc();
        chk("p9_irq_set", 64'(irq), 64'(1));
        rd(9);
        chk("p9_rd", 64'(reg_rdata), 64'h0003_0084);
        wr(9, 32'h0002_0000);
        chk("p9_irq_hold", 64'(irq), 64'(1));
        cyc();
        chk("p9_irq_clr", 64'(irq), 64'(0));

        // 4: W1C collides with a new falling edge; set wins
        wr(9, 32'h0000_0104);
        bidir_in[9] = 1'b0;
        idle(2);
        wr(9, 32'h0004_0104);
        rd(9);
        chk("p9_w1c_collide", 64'(reg_rdata), 64'h0004_0104);
        wr(9, 32'h0004_0000);
        wr(40, 32'hFFFF_FFFF);
        rd(40);
        chk("oor_rdata", 64'(reg_rdata), 64'(0));
        chk("oor_rvalid", 64'(reg_rvalid), 64'(1));

        // 5: reset during a read with a pend set
        wr(3, 32'h0000_0084);
        bidir_in[3] = 1'b1;
        idle(5);
        chk("p3_irq", 64'(irq), 64'(1));
        rst = 1'b1; reg_re = 1'b1; reg_addr = AW'(3);
        cyc();
        rst = 1'b0; reg_re = 1'b0;
        chk("mrst_rvalid", 64'(reg_rvalid), 64'(0));
        chk("mrst_irq", 64'(irq), 64'(0));
        chk("mrst_oe", 64'(bidir_oe), 64'(0));
        chk("mrst_out", 64'(bidir_out), 64'(0));
        chk("mrst_ie", 64'(bidir_ie), 64'(ALL1));
        chk("mrst_pu", 64'(bidir_pu), 64'(0));

        // Random traffic concentrated on pins 0..7 plus out-of-range addresses
        for (int c = 0; c < 1500; c++) begin
            reg_we    = ($urandom_range(0, 2) == 0);
            reg_re    = ($urandom_range(0, 2) == 0);
            reg_addr  = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(37, 63))
                                                     : AW'($urandom_range(0, 7));
            reg_wdata = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                int fp;
                fp = $urandom_range(0, 7);
                bidir_in[fp] = ~bidir_in[fp];
            end
            rst = ($urandom_range(0, 399) == 0);
            cyc();
        end
        reg_we = 1'b0; reg_re = 1'b0; rst = 1'b0;
        idle(4);

`ifdef GPIO_DEBOUNCE_EN
        // 6: debounce pulse widths on pin 2
        rst = 1'b1; bidir_in = '0;
        cyc();
        rst = 1'b0;
        idle(20);
        wr(2, 32'h0000_0084);
        bidir_in[2] = 1'b1;
        idle(15);
        bidir_in[2] = 1'b0;
        idle(40);
        chk("deb_short_irq", 64'(irq), 64'(0));
        rd(2);
        chk("deb_short_rd", 64'(reg_rdata), 64'h0000_0084);
        bidir_in[2] = 1'b1;
        cyc();
        idle(17);
        chk("deb_long_early", 64'(irq), 64'(0));
        cyc();
        chk("deb_long_irq_lag", 64'(irq), 64'(0));
        cyc();
        chk("deb_long_irq", 64'(irq), 64'(1));
        bidir_in[2] = 1'b0;
        idle(4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
